// File: rtl/s_axi_stream_buffer.sv
`default_nettype none
// ============================================================================
// Module   : s_axi_stream_buffer
// Brief    : AXI4-Stream slave that captures one frame into a 2**BUFSIZE-word
//            buffer and holds it for a local reader until ack.
//            Optional macro S_AXIS_PATTERN_CHECK_EN adds an incrementing-data checker.
// Revision : 1.0 - initial release
// ============================================================================
module s_axi_stream_buffer #(
  parameter int DWIDTH  = 32,
  parameter int BUFSIZE = 5
) (
  input  logic                  clk,
  input  logic                  xrst,
  input  logic                  tvalid,
  output logic                  tready,
  input  logic [DWIDTH-1:0]     tdata,
  input  logic [DWIDTH/8-1:0]   tstrb,
  input  logic                  tlast,
  input  logic [BUFSIZE-1:0]    rd_addr,
  output logic [DWIDTH-1:0]     rd_data,
  output logic                  done,
  output logic [BUFSIZE:0]      count,
  output logic                  overflow,
  input  logic                  ack,
  output logic                  err
);

  localparam int WORDS = 2 ** BUFSIZE;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [BUFSIZE:0] c_words = {1'b1, {BUFSIZE{1'b0}}};
  localparam logic [BUFSIZE:0] c_last  = {1'b0, {BUFSIZE{1'b1}}};

  logic [1:0]         state_q, state_d;
  logic [BUFSIZE:0]   wr_ptr_q, wr_ptr_d;
  logic               tready_q, tready_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic [DWIDTH-1:0]  rd_data_q;
  logic [DWIDTH-1:0]  mem [WORDS];

  logic               w_accept;
  logic               w_full;
  logic               w_frame_end;
  logic               w_release;
  logic [DWIDTH-1:0]  w_wdata;

  assign w_accept    = tvalid & tready_q & (state_q == S_RECV);
  assign w_full      = (wr_ptr_q == c_last);
  assign w_frame_end = w_accept & (tlast | w_full);
  assign w_release   = (state_q == S_DONE) & ack;

  for (genvar b = 0; b < DWIDTH/8; b++) begin : g_byte
    assign w_wdata[8*b +: 8] = tstrb[b] ? tdata[8*b +: 8] : 8'h00;
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: state_d = S_RECV;
      S_RECV: begin
        if (w_accept) begin
          wr_ptr_d = wr_ptr_q + (BUFSIZE+1)'(1);
          if (w_frame_end) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            ovf_d   = w_full & ~tlast;
          end
        end
      end
      S_DONE: begin
        if (ack) begin
          state_d  = S_RECV;
          wr_ptr_d = '0;
          done_d   = 1'b0;
          ovf_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Dropping ready on the same edge as the frame-end beat keeps the master from
    // pushing an extra beat into a held frame.
    tready_d = (state_d == S_RECV) && (wr_ptr_d < c_words);
  end

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      tready_q  <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      tready_q  <= tready_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      rd_data_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      mem[wr_ptr_q[BUFSIZE-1:0]] <= w_wdata;
    end
  end

`ifdef S_AXIS_PATTERN_CHECK_EN
  logic [DWIDTH-1:0] exp_q;
  logic              err_q;

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      exp_q <= DWIDTH'(1);
      err_q <= 1'b0;
    end else if (w_release) begin
      exp_q <= DWIDTH'(1);
      err_q <= 1'b0;
    end else if (w_accept) begin
      exp_q <= exp_q + DWIDTH'(1);
      if (tdata != exp_q) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign tready   = tready_q;
  assign done     = done_q;
  assign count    = wr_ptr_q;
  assign overflow = ovf_q;
  assign rd_data  = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_s_axi_stream_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_s_axi_stream_buffer
// Brief    : Directed, table-driven self-checking bench for s_axi_stream_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_s_axi_stream_buffer;

`ifdef S_AXIS_PATTERN_CHECK_EN
  localparam bit PC = 1'b1;
`else
  localparam bit PC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        xrst = 1'b1;
  logic        tvalid = 1'b0;
  logic        tready;
  logic [31:0] tdata = '0;
  logic [3:0]  tstrb = 4'hF;
  logic        tlast = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        done;
  logic [5:0]  count;
  logic        overflow;
  logic        ack = 1'b0;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  s_axi_stream_buffer #(.DWIDTH(32), .BUFSIZE(5)) dut (
    .clk(clk), .xrst(xrst), .tvalid(tvalid), .tready(tready), .tdata(tdata),
    .tstrb(tstrb), .tlast(tlast), .rd_addr(rd_addr), .rd_data(rd_data),
    .done(done), .count(count), .overflow(overflow), .ack(ack), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        tvalid;
    logic [31:0] tdata;
    logic        tlast;
    logic        ack;
    logic        e_tready;
    logic        e_done;
    logic [5:0]  e_count;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic status(input string tag, input logic r, input logic d,
                        input logic [5:0] c, input logic o);
    chk({tag, ".tready"},   32'(tready),   32'(r));
    chk({tag, ".done"},     32'(done),     32'(d));
    chk({tag, ".count"},    32'(count),    32'(c));
    chk({tag, ".overflow"}, 32'(overflow), 32'(o));
  endtask

  // Inputs change 1 time unit after an edge; outputs are sampled there too.
  task automatic step(input logic v, input logic [31:0] d, input logic [3:0] s,
                      input logic l, input logic a);
    tvalid = v; tdata = d; tstrb = s; tlast = l; ack = a;
    @(posedge clk); #1;
    tvalid = 1'b0; ack = 1'b0; tlast = 1'b0; tstrb = 4'hF;
  endtask

  task automatic apply_vec(input int i);
    step(vecs[i].tvalid, vecs[i].tdata, 4'hF, vecs[i].tlast, vecs[i].ack);
    status($sformatf("vec%0d", i), vecs[i].e_tready, vecs[i].e_done,
           vecs[i].e_count, vecs[i].e_ovf);
  endtask

  task automatic read_chk(input logic [4:0] a, input logic [31:0] exp);
    rd_addr = a;
    @(posedge clk); #1;
    chk($sformatf("rd[%0d]", a), rd_data, exp);
  endtask

  task automatic full_frame(input logic last_on_end, input logic e_ovf);
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 32'(100 + i), 4'hF, last_on_end && (i == 31), 1'b0);
      if (i == 30) status("full.b31", 1'b1, 1'b0, 6'd31, 1'b0);
    end
    status("full.end", 1'b0, 1'b1, 6'd32, e_ovf);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sd [3];
    logic [3:0]  ss [3];
    int k;
    int cyc;
    logic v;

    //             tvalid tdata   tlast ack  rdy  done cnt   ovf
    vecs[0] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0};
    vecs[1] = '{1'b1, 32'h1,  1'b0, 1'b0, 1'b1, 1'b0, 6'd1, 1'b0};
    vecs[2] = '{1'b1, 32'h2,  1'b0, 1'b0, 1'b1, 1'b0, 6'd2, 1'b0};
    vecs[3] = '{1'b1, 32'h3,  1'b0, 1'b0, 1'b1, 1'b0, 6'd3, 1'b0};
    vecs[4] = '{1'b1, 32'h4,  1'b1, 1'b0, 1'b0, 1'b1, 6'd4, 1'b0};
    vecs[5] = '{1'b1, 32'h63, 1'b0, 1'b0, 1'b0, 1'b1, 6'd4, 1'b0};
    vecs[6] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0};
    vecs[7] = '{1'b1, 32'hA,  1'b0, 1'b0, 1'b1, 1'b0, 6'd1, 1'b0};
    vecs[8] = '{1'b1, 32'hB,  1'b1, 1'b0, 1'b0, 1'b1, 6'd2, 1'b0};

    #1;
    status("reset", 1'b0, 1'b0, 6'd0, 1'b0);
    chk("reset.err", 32'(err), 32'h0);
    chk("reset.rd_data", rd_data, 32'h0);
    repeat (3) @(posedge clk);
    #1 xrst = 1'b0;

    for (int i = 0; i <= 5; i++) apply_vec(i);
    for (int i = 0; i < 4; i++) read_chk(5'(i), 32'(i + 1));
    for (int i = 6; i <= 8; i++) apply_vec(i);
    read_chk(5'd0, 32'hA);
    read_chk(5'd1, 32'hB);

    // Buffer fills without tlast; extra beats must be refused.
    step(1'b0, 32'h0, 4'hF, 1'b0, 1'b1);
    status("ack1", 1'b1, 1'b0, 6'd0, 1'b0);
    chk("ack1.err", 32'(err), 32'h0);
    full_frame(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'hDEAD, 4'hF, 1'b0, 1'b0);
      status("hold33", 1'b0, 1'b1, 6'd32, 1'b1);
    end
    read_chk(5'd31, 32'd131);

    step(1'b0, 32'h0, 4'hF, 1'b0, 1'b1);
    status("ack2", 1'b1, 1'b0, 6'd0, 1'b0);
    full_frame(1'b1, 1'b0);

    // Random tvalid gaps, byte-strobe masking, then async reset mid-frame.
    step(1'b0, 32'h0, 4'hF, 1'b0, 1'b1);
    status("ack3", 1'b1, 1'b0, 6'd0, 1'b0);
    sd[0] = 32'hFFFF_FFFF; ss[0] = 4'b0101;
    sd[1] = 32'h0000_0011; ss[1] = 4'hF;
    sd[2] = 32'h0000_0022; ss[2] = 4'hF;
    rd_addr = 5'd0;
    k = 0;
    cyc = 0;
    while (k < 3 && cyc < 100) begin
      v = 1'($urandom_range(0, 1));
      step(v, sd[k], ss[k], 1'b0, 1'b0);
      if (v) k++;
      cyc++;
      chk("rand.count", 32'(count), 32'(k));
    end
    chk("rand.beats", 32'(k), 32'd3);
    step(1'b0, 32'h0, 4'hF, 1'b0, 1'b0);
    chk("strb.rd0", rd_data, 32'h00FF_00FF);
    #2 xrst = 1'b1;
    #1;
    status("midrst", 1'b0, 1'b0, 6'd0, 1'b0);
    chk("midrst.rd_data", rd_data, 32'h0);
    @(posedge clk);
    #1 xrst = 1'b0;
    step(1'b0, 32'h0, 4'hF, 1'b0, 1'b0);
    status("post_rst", 1'b1, 1'b0, 6'd0, 1'b0);
    step(1'b1, 32'h55, 4'hF, 1'b0, 1'b0);
    step(1'b1, 32'h66, 4'hF, 1'b1, 1'b0);
    status("post_rst.frame", 1'b0, 1'b1, 6'd2, 1'b0);
    read_chk(5'd0, 32'h55);
    read_chk(5'd1, 32'h66);

    // Pattern checker: mismatch on the third beat is sticky until ack.
    step(1'b0, 32'h0, 4'hF, 1'b0, 1'b1);
    chk("pat.ack0.err", 32'(err), 32'h0);
    sd[0] = 32'd1; sd[1] = 32'd2; sd[2] = 32'd7;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, sd[i], 4'hF, 1'b0, 1'b0);
      chk($sformatf("pat.bad%0d.err", i), 32'(err), 32'(PC && i == 2));
    end
    step(1'b1, 32'd4, 4'hF, 1'b1, 1'b0);
    chk("pat.bad3.err", 32'(err), 32'(PC));
    chk("pat.bad.done", 32'(done), 32'h1);
    step(1'b0, 32'h0, 4'hF, 1'b0, 1'b1);
    chk("pat.ack.err", 32'(err), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 32'(i), 4'hF, i == 3, 1'b0);
      chk($sformatf("pat.good%0d.err", i), 32'(err), 32'h0);
    end
    status("pat.good", 1'b0, 1'b1, 6'd3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/s_axi_stream_buffer.md
Name: s_axi_stream_buffer

Overview:
AXI4-Stream slave that receives one frame into an internal buffer of 2**BUFSIZE words. It then holds the frame for a local consumer, which reads it through a synchronous read port and releases it with ack. It is the receiving counterpart of the team's stream masters and is used as a loopback sink for stream traffic and for pattern checking.

Parameters:
DWIDTH, 32, stream data width in bits; must be a multiple of 8.
BUFSIZE, 5, log2 of buffer depth; WORDS = 2**BUFSIZE.

Ports:
clk  input  1  clock; all logic on rising edge
xrst  input  1  reset; asynchronous, active-high
tvalid  input  1  stream beat valid
tready  output  1  stream ready (registered)
tdata  input  DWIDTH  stream data
tstrb  input  DWIDTH/8  byte strobes
tlast  input  1  last beat of frame
rd_addr  input  BUFSIZE  buffer read address
rd_data  output  DWIDTH  buffer read data, 1-cycle latency
done  output  1  frame complete and held
count  output  BUFSIZE+1  beats accepted in current/held frame (0..WORDS)
overflow  output  1  buffer filled without tlast (sticky)
ack  input  1  consumer release of held frame
err  output  1  pattern mismatch (sticky); see Optional Feature

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. xrst=1 immediately forces: state S_IDLE, tready=0, done=0, count=0, overflow=0, err=0, rd_data=0, wr_ptr=0. Buffer memory is not reset.
- States:
  - S_IDLE=0 -> S_RECV at the first edge after xrst deasserts.
  - S_RECV=1 -> S_DONE on the frame-end beat.
  - S_DONE=2 -> S_RECV on ack. Any illegal encoding -> S_IDLE.
- Beat acceptance: a beat is accepted at an edge where tvalid=1 and tready=1. On acceptance:
  - mem[wr_ptr] <= tdata, with bytes whose tstrb bit is 0 written as 8'h00.
  - wr_ptr and count increment by 1.
  - When tready=0, tvalid/tdata are ignored; there is no transfer.
- tready is registered; its next value = (next state is S_RECV) and (next wr_ptr < WORDS).
  - It rises at the first edge after reset release and after each ack.
  - It falls at the same edge that accepts the frame-end beat, so no extra beat is ever taken.
- Frame end is the accepted beat with tlast=1, or the accepted beat at wr_ptr=WORDS-1 (buffer full), whichever comes first. At that edge:
  - state <= S_DONE and done <= 1.
  - overflow <= 1 only if the buffer filled and tlast=0 on that beat.
  - tlast on exactly beat WORDS does not set overflow.
- S_DONE: count, done and overflow are held; tvalid is ignored.
- ack:
  - Sampled only in S_DONE. At that edge: wr_ptr=0, count=0, done=0, overflow=0, err=0, state <= S_RECV, tready <= 1.
  - ack in S_IDLE or S_RECV has no effect.
- Read port: rd_data <= mem[rd_addr] every edge in all states; the result is valid one cycle after rd_addr. A read of an address being written in the same cycle returns the old contents.
- Reset mid-frame discards the partial frame (count=0). The next frame is written from address 0.
- count width BUFSIZE+1 holds the value WORDS without wrap. wr_ptr never wraps, because tready is low once wr_ptr=WORDS.

Optional Feature:
Macro S_AXIS_PATTERN_CHECK_EN.
- Defined:
  - An expected-value register starts at 1 after reset and after ack, and increments on every accepted beat.
  - Any accepted beat with tdata != expected sets err=1. err is sticky until ack or reset.
- Not defined: err is tied to 0 and there is no checker logic.

Test Plan:
- Reset release, master sends 4 beats 1,2,3,4 with tlast on 4, all tstrb=1 -> done=1, count=4, overflow=0, tready low after the 4th accept; rd_addr 0..3 returns 1..4 one cycle later.
- Master sends 32 beats (BUFSIZE=5) with no tlast -> 32 accepted, done=1, count=32, overflow=1; 33rd beat held with tvalid=1 is not accepted.
- 32 beats with tlast on the 32nd -> count=32, overflow=0.
- Frame held, ack pulsed 1 cycle -> done=0, count=0 next cycle, tready=1; second frame of 2 beats 0xA,0xB -> rd_addr 0,1 return 0xA,0xB.
- tvalid toggling randomly, beat with tstrb=4'b0101 and tdata=0xFFFFFFFF -> stored as 0x00FF00FF; xrst asserted after 3 beats -> tready=0 and count=0 immediately, next frame written from address 0.
- With S_AXIS_PATTERN_CHECK_EN: beats 1,2,7,4 -> err=1 after the 3rd accept; ack clears err; beats 1,2,3 -> err stays 0.
